// File: rtl/keypad_entry_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_entry_ctrl
//
// Turns the raw 12-bit key vector from keypad_scan into debounced single-shot
// key events. The controller collects up to DIGITS decimal keys into a BCD
// entry buffer. '*' clears the buffer and '#' commits it. A committed entry is
// offered to the consumer over a valid/ready handshake.
//
// Ports
//   clk          in   1           system clock, rising edge
//   rst          in   1           asynchronous active-high reset
//   key_data     in   12          key vector: bits 0..8 = keys 1..9,
//                                 bit 9 = '*', bit 10 = key 0, bit 11 = '#'
//   key_code     out  4           code of the last accepted key
//                                 (0..9, '*' = 4'hA, '#' = 4'hB)
//   key_stb      out  1           one-cycle pulse when a key is accepted
//   buf_bcd      out  4*DIGITS    live entry buffer, newest digit in [3:0]
//   buf_len      out  4           number of digits in the buffer
//   entry_bcd    out  4*DIGITS    committed entry, held until the next commit
//   entry_len    out  4           digit count of the committed entry
//   entry_valid  out  1           a committed entry is waiting
//   entry_ready  in   1           the consumer takes the entry
//   key_err      out  1           one-cycle pulse when an accepted key is
//                                 rejected
//
// Parameters
//   DEB_CYCLES   identical samples needed to accept a press or a release
//                (2..255)
//   DIGITS       maximum digits per entry (1..8)
// -----------------------------------------------------------------------------
module keypad_entry_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int DIGITS     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           key_data,
    output logic [3:0]            key_code,
    output logic                  key_stb,
    output logic [4*DIGITS-1:0]   buf_bcd,
    output logic [3:0]            buf_len,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [3:0]            entry_len,
    output logic                  entry_valid,
    input  logic                  entry_ready,
    output logic                  key_err
);

    localparam int         W        = 4 * DIGITS;
    localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [3:0] DIGITS_L = 4'(DIGITS);
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    // -------------------------------------------------------------------------
    // Key vector to key code. The sample register holds a one-hot vector
    // whenever the FSM is able to accept, so the loop order is irrelevant.
    // -------------------------------------------------------------------------
    function automatic logic [3:0] decode_key(input logic [11:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) c = 4'(i + 1);
        end
        if (v[9])  c = KEY_STAR;
        if (v[10]) c = 4'd0;
        if (v[11]) c = KEY_HASH;
        return c;
    endfunction

    // FSM state
    state_t      state, state_next;
    logic [11:0] sample, sample_next;
    logic [7:0]  count, count_next;
    logic        accept;

    // Datapath next values
    logic [3:0]  acc_code;
    logic [3:0]  key_code_next;
    logic        key_err_next;
    logic [W-1:0] buf_bcd_next;
    logic [3:0]  buf_len_next;
    logic [W-1:0] entry_bcd_next;
    logic [3:0]  entry_len_next;
    logic        entry_valid_next;

    // A vector is one-hot when it is nonzero and clearing its lowest set bit
    // leaves nothing behind.
    logic key_onehot;
    assign key_onehot = (key_data != 12'd0) &&
                        ((key_data & (key_data - 12'd1)) == 12'd0);

    // -------------------------------------------------------------------------
    // Process 1: state register
    // -------------------------------------------------------------------------
    // NOTE: every register here, including the sample register and the
    // debounce counter, is cleared by reset. No storage is left unreset, so a
    // reset in the middle of a press cannot leak a stale event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sample <= 12'd0;
            count  <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register update
            // on the same edge independent of statement order.
            state  <= state_next;
            sample <= sample_next;
            count  <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // The first one-hot sample loads count = 1. DEBOUNCE accepts on the sample
    // that finds count == DEB_CYCLES-1, which is the DEB_CYCLES-th identical
    // sample. RELEASE counts zero samples in the same way, starting from the
    // zero sample that left HELD. Any nonzero glitch during RELEASE restarts
    // the count from 0.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first. That way no
        // path leaves a signal unassigned, and no latch is inferred.
        state_next  = state;
        sample_next = sample;
        count_next  = count;
        accept      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (key_onehot) begin
                    sample_next = key_data;
                    count_next  = 8'd1;
                    state_next  = S_DEBOUNCE;
                end
            end

            S_DEBOUNCE: begin
                if (key_data == sample) begin
                    if (count == CNT_LAST) begin
                        accept     = 1'b1;
                        state_next = S_HELD;
                    end else begin
                        count_next = count + 8'd1;
                    end
                end else if (key_onehot) begin
                    // A different key is bouncing in: follow it and restart.
                    sample_next = key_data;
                    count_next  = 8'd1;
                end else begin
                    state_next = S_IDLE;
                end
            end

            S_HELD: begin
                // A held key never repeats. Only a full release is watched.
                if (key_data == 12'd0) begin
                    count_next = 8'd1;
                    state_next = S_RELEASE;
                end
            end

            S_RELEASE: begin
                if (key_data == 12'd0) begin
                    if (count == CNT_LAST) begin
                        state_next = S_IDLE;
                    end else begin
                        count_next = count + 8'd1;
                    end
                end else begin
                    count_next = 8'd0;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: output logic
    // Computes the accept actions and the handshake. The handshake is applied
    // first, so a '#' commit on the same edge overrides the drop of
    // entry_valid.
    // -------------------------------------------------------------------------
    always_comb begin
        acc_code         = decode_key(sample);
        key_code_next    = key_code;
        key_err_next     = 1'b0;
        buf_bcd_next     = buf_bcd;
        buf_len_next     = buf_len;
        entry_bcd_next   = entry_bcd;
        entry_len_next   = entry_len;
        entry_valid_next = entry_valid;

        if (entry_valid && entry_ready) begin
            entry_valid_next = 1'b0;
        end

        if (accept) begin
            key_code_next = acc_code;

            if (acc_code <= 4'd9) begin
                if (buf_len < DIGITS_L) begin
                    buf_bcd_next = (buf_bcd << 4) | W'(acc_code);
                    buf_len_next = buf_len + 4'd1;
                end else begin
                    key_err_next = 1'b1;
                end
            end else if (acc_code == KEY_STAR) begin
                buf_bcd_next = '0;
                buf_len_next = 4'd0;
            end else begin
                // '#': an empty buffer, or a slot that is still occupied and
                // not being drained this edge, rejects the commit.
                if (buf_len == 4'd0) begin
                    key_err_next = 1'b1;
                end else if (entry_valid && !entry_ready) begin
                    key_err_next = 1'b1;
                end else begin
                    entry_bcd_next   = buf_bcd;
                    entry_len_next   = buf_len;
                    entry_valid_next = 1'b1;
                    buf_bcd_next     = '0;
                    buf_len_next     = 4'd0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output and datapath registers. Every output is driven from a flop, so
    // entry_ready never reaches an output combinationally.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code    <= 4'd0;
            key_stb     <= 1'b0;
            key_err     <= 1'b0;
            buf_bcd     <= '0;
            buf_len     <= 4'd0;
            entry_bcd   <= '0;
            entry_len   <= 4'd0;
            entry_valid <= 1'b0;
        end else begin
            key_code    <= key_code_next;
            key_stb     <= accept;
            key_err     <= key_err_next;
            buf_bcd     <= buf_bcd_next;
            buf_len     <= buf_len_next;
            entry_bcd   <= entry_bcd_next;
            entry_len   <= entry_len_next;
            entry_valid <= entry_valid_next;
        end
    end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencing controller that sits downstream of `keypad_scan` and turns its raw 12-bit key vector into debounced, single-shot key events. It assembles up to `DIGITS` decimal keys into a BCD entry buffer, uses `*` to clear and `#` to commit, and hands each committed entry to the consumer over a valid/ready handshake. It is the only consumer of `key_data` and owns all press/release sequencing for the keypad path.

## Interface
- `DEB_CYCLES`, default 4: consecutive identical samples required to accept a press or a release; legal range 2..255.
- `DIGITS`, default 4: maximum digits per entry; legal range 1..8.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `key_data`  in  12: key vector from `keypad_scan`, one-hot when exactly one key is pressed. Bit map: bits 0..8 = keys 1..9, bit 9 = `*`, bit 10 = key 0, bit 11 = `#`.
- `key_code`  out  4: code of the last accepted key. Digits = 0..9, `*` = 4'hA, `#` = 4'hB.
- `key_stb`  out  1: one-cycle pulse on accept; `key_code` is valid in the same cycle.
- `buf_bcd`  out  4*DIGITS: live entry buffer; newest digit in bits [3:0].
- `buf_len`  out  4: number of digits in the buffer, 0..DIGITS.
- `entry_bcd`  out  4*DIGITS: committed entry; stable while `entry_valid` is high.
- `entry_len`  out  4: digit count of the committed entry, 1..DIGITS.
- `entry_valid`  out  1: committed entry available.
- `entry_ready`  in  1: consumer accepts the entry.
- `key_err`  out  1: one-cycle pulse when an accepted key is rejected.

## Operation
- Reset, asynchronous: state goes to IDLE and every output and internal register clears to 0 (`key_code`, `key_stb`, `buf_*`, `entry_*`, `key_err`, debounce counter, sample register). Reset asserted mid-press discards the press with no event.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE: if `key_data` is one-hot, capture it in the sample register, set count = 1, and go to DEBOUNCE. Zero or multi-hot input leaves the FSM in IDLE.
- DEBOUNCE, when `key_data` equals the sample:
  - If count == DEB_CYCLES-1, accept the key and go to HELD.
  - Otherwise increment count.
- DEBOUNCE, when `key_data` differs from the sample:
  - One-hot input: recapture it and set count = 1.
  - Zero or multi-hot input: return to IDLE.
- HELD: no repeat while the key is held. When `key_data` == 0, set count = 1 and go to RELEASE.
- RELEASE: `key_data` == 0 increments count. When count reaches DEB_CYCLES-1 on a zero sample, go to IDLE. Any nonzero sample resets count to 0 and the FSM stays in RELEASE with no new event.
- Accept actions, taken in the accept cycle; `key_stb` always pulses:
  - Digit with `buf_len` < DIGITS: `buf_bcd` <= {buf_bcd[4*DIGITS-5:0], digit}, then `buf_len`++.
  - Digit with `buf_len` == DIGITS: `key_err` pulses and the buffer is unchanged.
  - `*`: `buf_bcd` <= 0, `buf_len` <= 0. Never an error.
  - `#` with `buf_len` == 0: `key_err` pulses.
  - `#` while the slot is occupied (`entry_valid` && !`entry_ready`): `key_err` pulses and the buffer is retained.
  - `#` otherwise: `entry_bcd` <= `buf_bcd`, `entry_len` <= `buf_len`, `entry_valid` <= 1, buffer cleared.
- Handshake: the transfer completes on the edge where `entry_valid` && `entry_ready`; `entry_valid` drops next cycle unless a `#` commit lands on the same edge. A same-edge commit wins: the new entry is loaded and `entry_valid` stays 1.
- `entry_bcd` and `entry_len` hold until the next commit. They do not clear on handshake.

## Timing
- Press latency: the first one-hot sample is taken at edge k. The accept registers at edge k+DEB_CYCLES-1, so `key_stb`, `key_code`, `buf_*` and `entry_*` are all visible after that edge.
- Minimum key period: DEB_CYCLES cycles pressed plus DEB_CYCLES cycles released.
- `key_stb` and `key_err` are single-cycle pulses, registered.
- `entry_ready` has no combinational path to any output.

## Test plan
- Press key 1 (bit 0) for 6 cycles, then release, with DEB_CYCLES=4 → exactly one `key_stb` with `key_code`=1, on the 4th stable edge; `buf_bcd`=16'h0001, `buf_len`=1.
- Bounce: toggle bit 0 / zero every cycle for 5 cycles, then hold → no event during bouncing; one event 4 edges after the stable hold begins.
- Keys 1,2,3,4,5 → `buf_bcd`=16'h1234, `buf_len`=4; key 5 produces a `key_err` pulse. Then `#` → `entry_bcd`=16'h1234, `entry_len`=4, `entry_valid`=1, buffer cleared.
- With `entry_ready` held 0: enter 7, `#`, 8, `#` → the second `#` produces `key_err`, buffer keeps 16'h0008, `entry_bcd` stays 16'h0007. Then raise `entry_ready` for one cycle → `entry_valid` falls.
- Enter 9, `*`, `#` → buffer cleared by `*`; `#` produces `key_err`; `entry_valid` stays 0.
- Assert `rst` mid-DEBOUNCE and while `entry_valid`=1 → all outputs read 0 immediately (asynchronous); no event after `rst` deasserts until a fresh press completes the full DEB_CYCLES count.
